// File: rtl/indicator_scanner.sv
`default_nettype none
// ============================================================================
// Module      : indicator_scanner
// Description : Recovers the value shown on a multiplexed 4-digit,
//               7-segment display by snooping the digit-select and segment
//               lines. Each digit is captured once its select/pattern pair
//               has been stable for STABLE_CYCLES samples. A frame completes
//               once all four digits have been seen.
// Ports       : clk         - clock, rising edge
//               rst_n       - asynchronous active-low reset
//               digits      - one-hot digit select (4'b0000 = idle)
//               segments    - active-low segments, bit7 = DP, bits 6..0 = G..A
//               value       - last complete frame, nibble i = digit i code
//               frame_valid - one-cycle pulse when value updates
//               frame_error - value contains an invalid pattern / multi-hot
//               timeout     - one-cycle pulse when a partial frame is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module indicator_scanner #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digits,
    input  logic [7:0]  segments,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        timeout
);

    localparam logic [3:0] C_STABLE  = 4'(STABLE_CYCLES);
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [3:0]  samp_dig_q;     // input sample register
    logic [7:0]  samp_seg_q;
    logic [3:0]  prev_dig_q;     // previous sample, for stability compare
    logic [7:0]  prev_seg_q;
    logic [3:0]  stab_cnt_q, stab_cnt_d;
    logic [7:0]  tmo_cnt_q,  tmo_cnt_d;
    logic [3:0]  seen_q,     seen_d;
    logic        err_q,      err_d;
    logic [15:0] shadow_q,   shadow_d;
    logic [15:0] value_q,    value_d;
    logic        fv_q,       fv_d;
    logic        fe_q,       fe_d;
    logic        to_q,       to_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_same;
    logic        w_capture;
    logic        w_idle;
    logic        w_onehot;
    logic [3:0]  w_code;
    logic        w_bad;
    logic        w_restart;
    logic [3:0]  w_base_seen;
    logic        w_base_err;
    logic [3:0]  w_new_seen;
    logic        w_new_err;

    // Segment decoder: returns {invalid, code}.
    function automatic logic [4:0] decode_seg(input logic [7:0] seg);
        logic [4:0] r;
        case (seg)
            8'hC0:   r = 5'h00;
            8'hF9:   r = 5'h01;
            8'hA4:   r = 5'h02;
            8'hB0:   r = 5'h03;
            8'h99:   r = 5'h04;
            8'h92:   r = 5'h05;
            8'h82:   r = 5'h06;
            8'hF8:   r = 5'h07;
            8'h80:   r = 5'h08;
            8'h90:   r = 5'h09;
            8'h00:   r = 5'h0A;   // lamp test, all segments lit
            default: r = 5'h1F;
        endcase
        return r;
    endfunction

    assign w_same   = (samp_dig_q == prev_dig_q) && (samp_seg_q == prev_seg_q);
    assign w_idle   = (samp_dig_q == 4'b0000);
    assign w_onehot = !w_idle && ((samp_dig_q & (samp_dig_q - 4'd1)) == 4'b0000);
    assign {w_bad, w_code} = decode_seg(samp_seg_q);

    // Stability counter saturates at C_STABLE; a change restarts it at 1.
    always_comb begin
        stab_cnt_d = 4'd1;
        if (w_same) begin
            stab_cnt_d = (stab_cnt_q == C_STABLE) ? stab_cnt_q : stab_cnt_q + 4'd1;
        end
    end

    // Capture only on the edge at which the count first reaches C_STABLE;
    // a saturated counter therefore never re-triggers.
    assign w_capture = (stab_cnt_d == C_STABLE) && (stab_cnt_q != C_STABLE);

    // A repeated digit before the mask is full starts a new frame.
    assign w_restart   = ((samp_dig_q & seen_q) != 4'b0000) && (seen_q != 4'b1111);
    assign w_base_seen = w_restart ? 4'b0000 : seen_q;
    assign w_base_err  = w_restart ? 1'b0    : err_q;
    assign w_new_seen  = w_base_seen | samp_dig_q;
    assign w_new_err   = w_base_err | w_bad;

    // ------------------------------------------------------------------
    // Frame assembly, completion and timeout
    // ------------------------------------------------------------------
    always_comb begin
        seen_d    = seen_q;
        err_d     = err_q;
        shadow_d  = shadow_q;
        value_d   = value_q;
        fe_d      = fe_q;
        fv_d      = 1'b0;
        to_d      = 1'b0;
        tmo_cnt_d = tmo_cnt_q;

        if (w_capture && w_onehot) begin
            for (int i = 0; i < 4; i++) begin
                if (samp_dig_q[i]) begin
                    shadow_d[4*i +: 4] = w_code;
                end
            end
            tmo_cnt_d = 8'd0;
            if (w_new_seen == 4'b1111) begin
                value_d = shadow_d;
                fe_d    = w_new_err;
                seen_d  = 4'b0000;
                err_d   = 1'b0;
                fv_d    = 1'b1;
            end else begin
                seen_d  = w_new_seen;
                err_d   = w_new_err;
            end
        end else begin
            // Multi-hot select: flag the frame, keep the mask as is.
            if (w_capture && !w_idle) begin
                err_d = 1'b1;
            end
            // Idle windows and multi-hot captures do not restart the
            // timeout; only one-hot captures do.
            if (seen_q != 4'b0000) begin
                if (tmo_cnt_q + 8'd1 == C_TIMEOUT) begin
                    seen_d    = 4'b0000;
                    err_d     = 1'b0;
                    to_d      = 1'b1;
                    tmo_cnt_d = 8'd0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end else begin
                tmo_cnt_d = 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_dig_q <= 4'b0000;
            samp_seg_q <= 8'hFF;
            prev_dig_q <= 4'b0000;
            prev_seg_q <= 8'hFF;
            stab_cnt_q <= 4'd0;
            tmo_cnt_q  <= 8'd0;
            seen_q     <= 4'b0000;
            err_q      <= 1'b0;
            shadow_q   <= 16'h0000;
            value_q    <= 16'h0000;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            samp_dig_q <= digits;
            samp_seg_q <= segments;
            prev_dig_q <= samp_dig_q;
            prev_seg_q <= samp_seg_q;
            stab_cnt_q <= stab_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            value_q    <= value_d;
            fv_q       <= fv_d;
            fe_q       <= fe_d;
            to_q       <= to_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = fv_q;
    assign frame_error = fe_q;
    assign timeout     = to_q;

endmodule
`default_nettype wire

// File: tb/tb_indicator_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_indicator_scanner
// Description : Directed self-checking bench for indicator_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_indicator_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  digits;
    logic [7:0]  segments;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_error;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int fv_cnt;
    int to_cnt;
    int fv_at;

    indicator_scanner #(
        .STABLE_CYCLES (4),
        .TIMEOUT       (255)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .segments    (segments),
        .value       (value),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one digit/pattern pair for n cycles, sampling outputs 1ns after
    // each rising edge; fv_at records the cycle index of the last pulse.
    task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
        digits   = d;
        segments = s;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                fv_cnt++;
                fv_at = k;
            end
            if (timeout) to_cnt++;
        end
    endtask

    task automatic clr_counts();
        fv_cnt = 0;
        to_cnt = 0;
        fv_at  = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        digits   = 4'b0000;
        segments = 8'hFF;
        clr_counts();
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_value", 32'(value), 32'h0);
        chk_val("rst_fv",    32'(frame_valid), 32'h0);
        chk_val("rst_fe",    32'(frame_error), 32'h0);
        chk_val("rst_to",    32'(timeout), 32'h0);
        rst_n = 1'b1;
        hold(4'b0000, 8'hFF, 8);

        // Basic frame 4321, latency S+1 = 5 on the last digit
        clr_counts();
        hold(4'b0001, 8'hF9, 13);
        hold(4'b0010, 8'hA4, 13);
        hold(4'b0100, 8'hB0, 13);
        chk_val("basic_fv_early", 32'(fv_cnt), 32'd0);
        hold(4'b1000, 8'h99, 13);
        chk_val("basic_fv_cnt",  32'(fv_cnt), 32'd1);
        chk_val("basic_latency", 32'(fv_at), 32'd5);
        chk_val("basic_value",   32'(value), 32'h4321);
        chk_val("basic_fe",      32'(frame_error), 32'h0);

        // Glitch inside a hold of digit 0: glitch ignored, repeat restarts
        clr_counts();
        hold(4'b0001, 8'hF9, 6);
        hold(4'b0001, 8'h00, 1);
        hold(4'b0001, 8'hF9, 6);
        hold(4'b0010, 8'h92, 13);
        hold(4'b0100, 8'h82, 13);
        hold(4'b1000, 8'hF8, 13);
        chk_val("glitch_fv_cnt", 32'(fv_cnt), 32'd1);
        chk_val("glitch_d0",     32'(value[3:0]), 32'h1);
        chk_val("glitch_value",  32'(value), 32'h7651);
        chk_val("glitch_fe",     32'(frame_error), 32'h0);

        // Blank digit 2 -> code F, frame error
        clr_counts();
        hold(4'b0001, 8'hC0, 13);
        hold(4'b0010, 8'h80, 13);
        hold(4'b0100, 8'hFF, 13);
        hold(4'b1000, 8'h90, 13);
        chk_val("blank_fv_cnt", 32'(fv_cnt), 32'd1);
        chk_val("blank_value",  32'(value), 32'h9F80);
        chk_val("blank_fe",     32'(frame_error), 32'h1);

        // Multi-hot select inside a frame: error, nothing stored
        clr_counts();
        hold(4'b0001, 8'hF9, 13);
        hold(4'b0010, 8'hA4, 13);
        hold(4'b0011, 8'hC0, 13);
        hold(4'b0100, 8'hB0, 13);
        hold(4'b1000, 8'h99, 13);
        chk_val("multi_fv_cnt", 32'(fv_cnt), 32'd1);
        chk_val("multi_value",  32'(value), 32'h4321);
        chk_val("multi_fe",     32'(frame_error), 32'h1);

        // Order 0,1,0,1,2,3: restart on repeated 0, one pulse after digit 3
        clr_counts();
        hold(4'b0001, 8'hC0, 13);
        hold(4'b0010, 8'hF9, 13);
        hold(4'b0001, 8'hA4, 13);
        hold(4'b0010, 8'hB0, 13);
        hold(4'b0100, 8'h99, 13);
        chk_val("order_fv_early", 32'(fv_cnt), 32'd0);
        hold(4'b1000, 8'h92, 13);
        chk_val("order_fv_cnt", 32'(fv_cnt), 32'd1);
        chk_val("order_value",  32'(value), 32'h5432);
        chk_val("order_fe",     32'(frame_error), 32'h0);

        // Partial frame then idle: one timeout, value unchanged
        clr_counts();
        hold(4'b0001, 8'h90, 13);
        hold(4'b0010, 8'h80, 13);
        hold(4'b0000, 8'hFF, 255);
        chk_val("tmo_to_cnt", 32'(to_cnt), 32'd1);
        chk_val("tmo_fv_cnt", 32'(fv_cnt), 32'd0);
        chk_val("tmo_value",  32'(value), 32'h5432);
        chk_val("tmo_fe",     32'(frame_error), 32'h0);

        // Reset mid-frame
        clr_counts();
        hold(4'b0001, 8'hF9, 13);
        hold(4'b0010, 8'hA4, 13);
        hold(4'b0100, 8'hB0, 13);
        rst_n    = 1'b0;
        digits   = 4'b0000;
        segments = 8'hFF;
        #1;
        chk_val("mrst_value", 32'(value), 32'h0);
        chk_val("mrst_fv",    32'(frame_valid), 32'h0);
        chk_val("mrst_fe",    32'(frame_error), 32'h0);
        chk_val("mrst_to",    32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b0000, 8'hFF, 6);
        chk_val("mrst_no_pulse", 32'(fv_cnt + to_cnt), 32'd0);
        hold(4'b0001, 8'hF9, 13);
        hold(4'b0010, 8'hA4, 13);
        hold(4'b0100, 8'hB0, 13);
        hold(4'b1000, 8'h99, 13);
        chk_val("mrst_fv_cnt", 32'(fv_cnt), 32'd1);
        chk_val("mrst_value",  32'(value), 32'h4321);
        chk_val("mrst_fe2",    32'(frame_error), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
